// File: rtl/bch_pkg.sv
// Package for the t=2 binary BCH stream decoder.
// Holds the decoder state encoding and GF(2^m) helpers written for any m up
// to MAX_M. Field elements are passed zero-extended to MAX_M bits. The
// primitive polynomial is passed as MAX_M+1 bits, with its x^m term set.
package bch_pkg;

  localparam int MAX_M = 16;
  localparam int MAX_W = MAX_M + 1;

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    SOLVE = 2'd1,
    OUT   = 2'd2
  } state_e;

  // a * alpha: shift up, and fold the x^m term back in through the polynomial.
  function automatic logic [MAX_M-1:0] gf_mul_alpha(input logic [MAX_M-1:0] a,
                                                    input int m,
                                                    input logic [MAX_M:0] poly);
    logic [MAX_M:0] t;
    t = {a, 1'b0};
    if ((t & (MAX_W'(1) << m)) != '0) t = t ^ poly;
    return t[MAX_M-1:0];
  endfunction

  // a * alpha^-1: make a divisible by x by adding the polynomial when a[0]
  // is set, then shift down.
  function automatic logic [MAX_M-1:0] gf_mul_alpha_inv(input logic [MAX_M-1:0] a,
                                                        input logic [MAX_M:0] poly);
    logic [MAX_M:0] t;
    t = {1'b0, a};
    if (a[0]) t = t ^ poly;
    return t[MAX_M:1];
  endfunction

  // Shift-and-add product, reduced one alpha step at a time.
  function automatic logic [MAX_M-1:0] gf_mul(input logic [MAX_M-1:0] a,
                                              input logic [MAX_M-1:0] b,
                                              input int m,
                                              input logic [MAX_M:0] poly);
    logic [MAX_M-1:0] acc;
    logic [MAX_M-1:0] x;
    logic [MAX_M-1:0] bb;
    acc = '0;
    x   = a;
    bb  = b;
    for (int i = 0; i < MAX_M; i++) begin
      if (bb[0]) acc = acc ^ x;
      bb = bb >> 1;
      x  = gf_mul_alpha(x, m, poly);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf_mult.sv
// Combinational GF(2^GF_M) multiplier.
// Ports: a_i, b_i  field operands (GF_M bits)
//        p_o       a_i * b_i reduced by PRIM_POLY
module gf_mult
  import bch_pkg::*;
#(
  parameter int              GF_M      = 6,
  parameter logic [GF_M:0]   PRIM_POLY = 7'b1000011
) (
  input  logic [GF_M-1:0] a_i,
  input  logic [GF_M-1:0] b_i,
  output logic [GF_M-1:0] p_o
);

  assign p_o = GF_M'(gf_mul(MAX_M'(a_i), MAX_M'(b_i), GF_M, MAX_W'(PRIM_POLY)));

endmodule

// File: rtl/bch_stream_decoder.sv
// Bit-serial t=2 binary BCH decoder over GF(2^GF_M), with frame length
// N = 2^GF_M-1.
// The decoder works one frame at a time:
//   RECV  - takes in the frame, stores it and builds the syndromes S1 and S3.
//   SOLVE - runs for GF_M cycles and solves the error locator.
//   OUT   - runs a Chien search and emits one corrected bit per beat.
// Optional macro BCH_DEC_STATS_EN adds saturating statistics counters.
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   in_bit/in_valid/in_ready   input stream; beat k is code position k
//   out_bit/out_valid/out_ready output stream, position order 0..N-1
//   out_last                   marks beat N-1
//   out_err_cnt, out_uncorr    frame status, meaningful with out_last
//   stat_frames/corr/uncorr    statistics (BCH_DEC_STATS_EN only)
// Handshake: a beat transfers on a rising edge where valid && ready.
// While out_valid && !out_ready, every output is held stable.
module bch_stream_decoder
  import bch_pkg::*;
#(
  parameter int            GF_M      = 6,
  parameter logic [GF_M:0] PRIM_POLY = 7'b1000011
`ifdef BCH_DEC_STATS_EN
  , parameter int          STAT_W    = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_bit,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [1:0]        out_err_cnt,
  output logic              out_uncorr
`ifdef BCH_DEC_STATS_EN
  , output logic [STAT_W-1:0] stat_frames
  , output logic [STAT_W-1:0] stat_corr
  , output logic [STAT_W-1:0] stat_uncorr
`endif
);

  localparam int N = (1 << GF_M) - 1;
  typedef logic [GF_M-1:0] gf_t;
  localparam gf_t GF_ONE    = gf_t'(1);
  localparam gf_t POS_LAST  = gf_t'(N - 1);
  localparam gf_t POS_PEN   = gf_t'(N - 2);
  localparam gf_t STEP_LAST = gf_t'(GF_M - 1);

  function automatic gf_t mul_a(input gf_t v);
    return gf_t'(gf_mul_alpha(MAX_M'(v), GF_M, MAX_W'(PRIM_POLY)));
  endfunction

  function automatic gf_t mul_ainv(input gf_t v);
    return gf_t'(gf_mul_alpha_inv(MAX_M'(v), MAX_W'(PRIM_POLY)));
  endfunction

  state_e      state_q;
  logic [N-1:0] buf_q;
  gf_t         pos_q, step_q;
  gf_t         ak_q, a3k_q, s1_q, s3_q;
  gf_t         inv_q, sig1_q, sig2_q, x_q, x2_q;
  logic [1:0]  roots_q;
  logic        noloc_q;
  logic        in_ready_q, out_valid_q, out_bit_q, out_last_q, out_uncorr_q;
  logic [1:0]  out_err_q;

  logic        hs_in, hs_out, solve_last, in_out;
  gf_t         pos_inc, x_nxt, x2_nxt;
  gf_t         m0_a, m0_b, m0_p, m1_b, m1_p, m2_a, m2_b, m2_p;
  gf_t         sig2_d;
  logic        noloc_d, root0, root_nxt;
  logic [1:0]  roots_d, exp_roots;

  assign hs_in      = in_valid && in_ready_q;
  assign hs_out     = out_valid_q && out_ready;
  assign solve_last = (step_q == STEP_LAST);
  assign in_out     = (state_q == OUT);
  assign pos_inc    = pos_q + GF_ONE;
  assign x_nxt      = mul_ainv(x_q);
  assign x2_nxt     = mul_ainv(mul_ainv(x2_q));

  // In SOLVE, m0 squares the running power of S1.
  // m1 then multiplies that square by S1, or by S3 on the final step, when
  // the square is S1^-1.
  // m2 gives S1^2.
  // In OUT, m0 and m2 form sig1*x and sig2*x^2 for the next position.
  assign m0_a = in_out ? sig1_q : inv_q;
  assign m0_b = in_out ? x_nxt  : inv_q;
  assign m1_b = solve_last ? s3_q : s1_q;
  assign m2_a = in_out ? sig2_q : s1_q;
  assign m2_b = in_out ? x2_nxt : s1_q;

  gf_mult #(.GF_M(GF_M), .PRIM_POLY(PRIM_POLY)) u_m0 (.a_i(m0_a), .b_i(m0_b), .p_o(m0_p));
  gf_mult #(.GF_M(GF_M), .PRIM_POLY(PRIM_POLY)) u_m1 (.a_i(m0_p), .b_i(m1_b), .p_o(m1_p));
  gf_mult #(.GF_M(GF_M), .PRIM_POLY(PRIM_POLY)) u_m2 (.a_i(m2_a), .b_i(m2_b), .p_o(m2_p));

  assign sig2_d  = m2_p ^ m1_p;
  assign noloc_d = (s1_q == '0) && (s3_q != '0);
  // Position 0 has x = 1, so the locator test there is just sig1 ^ sig2.
  assign root0    = ((s1_q ^ sig2_d) == GF_ONE) && !noloc_d;
  assign root_nxt = ((m0_p ^ m2_p) == GF_ONE) && !noloc_q;
  assign roots_d  = roots_q + {1'b0, root_nxt};
  assign exp_roots = (sig1_q == '0 && sig2_q == '0) ? 2'd0 :
                     (sig2_q == '0)                 ? 2'd1 : 2'd2;

  // Every frame overwrites all N positions, so the buffer needs no reset.
  always_ff @(posedge clk) begin
    if (hs_in) buf_q[pos_q] <= in_bit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RECV;
      pos_q        <= '0;
      step_q       <= '0;
      ak_q         <= GF_ONE;
      a3k_q        <= GF_ONE;
      s1_q         <= '0;
      s3_q         <= '0;
      inv_q        <= GF_ONE;
      sig1_q       <= '0;
      sig2_q       <= '0;
      x_q          <= GF_ONE;
      x2_q         <= GF_ONE;
      roots_q      <= '0;
      noloc_q      <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_bit_q    <= 1'b0;
      out_last_q   <= 1'b0;
      out_err_q    <= '0;
      out_uncorr_q <= 1'b0;
    end else begin
      case (state_q)
        RECV: begin
          if (hs_in) begin
            if (in_bit) begin
              s1_q <= s1_q ^ ak_q;
              s3_q <= s3_q ^ a3k_q;
            end
            ak_q  <= mul_a(ak_q);
            a3k_q <= mul_a(mul_a(mul_a(a3k_q)));
            if (pos_q == POS_LAST) begin
              state_q    <= SOLVE;
              in_ready_q <= 1'b0;
              pos_q      <= '0;
              step_q     <= '0;
              inv_q      <= GF_ONE;
            end else begin
              pos_q <= pos_inc;
            end
          end
        end
        SOLVE: begin
          // inv_q walks through S1^(2^(k+1)-1). The square on the final step
          // gives S1^(2^GF_M-2), which is S1^-1.
          step_q <= step_q + GF_ONE;
          if (!solve_last) begin
            inv_q <= m1_p;
          end else begin
            inv_q       <= m0_p;
            sig1_q      <= s1_q;
            sig2_q      <= sig2_d;
            noloc_q     <= noloc_d;
            state_q     <= OUT;
            out_valid_q <= 1'b1;
            out_bit_q   <= buf_q[0] ^ root0;
            out_last_q  <= 1'b0;
            roots_q     <= {1'b0, root0};
            x_q         <= GF_ONE;
            x2_q        <= GF_ONE;
            pos_q       <= '0;
          end
        end
        OUT: begin
          if (hs_out) begin
            if (out_last_q) begin
              state_q      <= RECV;
              out_valid_q  <= 1'b0;
              out_bit_q    <= 1'b0;
              out_last_q   <= 1'b0;
              out_err_q    <= '0;
              out_uncorr_q <= 1'b0;
              in_ready_q   <= 1'b1;
              pos_q        <= '0;
              ak_q         <= GF_ONE;
              a3k_q        <= GF_ONE;
              s1_q         <= '0;
              s3_q         <= '0;
            end else begin
              pos_q     <= pos_inc;
              x_q       <= x_nxt;
              x2_q      <= x2_nxt;
              out_bit_q <= buf_q[pos_inc] ^ root_nxt;
              roots_q   <= roots_d;
              if (pos_q == POS_PEN) begin
                out_last_q   <= 1'b1;
                out_err_q    <= roots_d;
                out_uncorr_q <= noloc_q || (roots_d != exp_roots);
              end
            end
          end
        end
        default: state_q <= RECV;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_bit     = out_bit_q;
  assign out_last    = out_last_q;
  assign out_err_cnt = out_err_q;
  assign out_uncorr  = out_uncorr_q;

`ifdef BCH_DEC_STATS_EN
  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                input logic [STAT_W-1:0] b);
    logic [STAT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[STAT_W] ? '1 : s[STAT_W-1:0];
  endfunction

  logic [STAT_W-1:0] frames_q, corr_q, uncorr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frames_q <= '0;
      corr_q   <= '0;
      uncorr_q <= '0;
    end else if (hs_out && out_last_q) begin
      frames_q <= sat_add(frames_q, STAT_W'(1));
      if (out_uncorr_q) uncorr_q <= sat_add(uncorr_q, STAT_W'(1));
      else              corr_q   <= sat_add(corr_q, STAT_W'(out_err_q));
    end
  end

  assign stat_frames = frames_q;
  assign stat_corr   = corr_q;
  assign stat_uncorr = uncorr_q;
`endif

endmodule
